out_fm_st_ctrl: RTL and testbench

Controller that sequences the store of one output-feature-map tile from the on-chip output buffer to external memory. On a start pulse it latches the tile geometry and walks a 2-D column/row index (n0 columns × n1 rows). For each element it issues a buffer read, then forwards the returned word with its strided memory address over a valid/ready write channel. It sits between the convolution tile scheduler, which issues `start` and waits for `done`, and the memory write port.

---
 rtl/out_fm_pkg.sv | 22 ++
 rtl/st_tile_idx_counter.sv | 55 +++++
 rtl/out_fm_st_ctrl.sv | 169 ++++++++++++++++
 tb/tb_out_fm_st_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/out_fm_pkg.sv
// Shared definitions for the output-feature-map store controller.
package out_fm_pkg;

    // Default widths: tile dimension, memory word address, buffer address, data.
    localparam int unsigned CW = 16;
    localparam int unsigned AW = 32;
    localparam int unsigned BW = 12;
    localparam int unsigned DW = 32;

    // Store FSM state encoding.
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_STREAM = 2'd1;
    localparam logic [1:0] ST_DRAIN  = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    // True when another read fits: occupancy + in-flight - pop < 2.
    function automatic logic issue_ok(input logic [1:0] occ, input logic inflight,
                                      input logic pop);
        return (3'({1'b0, occ}) + 3'({2'b00, inflight})) < (3'd2 + 3'({2'b00, pop}));
    endfunction

endpackage

// File: rtl/st_tile_idx_counter.sv
// 2-D column/row index walker for one tile; advances once per issued read.
module st_tile_idx_counter #(
    parameter int unsigned CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_load,
    input  logic [CW-1:0] i_n0,
    input  logic [CW-1:0] i_n1,
    input  logic          i_en,
    output logic [CW-1:0] o_cnt0,
    output logic          o_wrap,
    output logic          o_last
);

    logic [CW-1:0] r_n0;
    logic [CW-1:0] r_n1;
    logic [CW-1:0] r_cnt0;
    logic [CW-1:0] r_cnt1;
    logic          w_wrap;
    logic          w_last;

    assign w_wrap = (r_cnt0 == (r_n0 - CW'(1)));
    assign w_last = w_wrap && (r_cnt1 == (r_n1 - CW'(1)));

    assign o_cnt0 = r_cnt0;
    assign o_wrap = w_wrap;
    assign o_last = w_last;

    // Latch geometry on load; step column, carry into row on column wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_n0   <= '0;
            r_n1   <= '0;
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else if (i_load) begin
            r_n0   <= i_n0;
            r_n1   <= i_n1;
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else if (i_en) begin
            if (w_last) begin
                r_cnt0 <= '0;
                r_cnt1 <= '0;
            end else if (w_wrap) begin
                r_cnt0 <= '0;
                r_cnt1 <= r_cnt1 + CW'(1);
            end else begin
                r_cnt0 <= r_cnt0 + CW'(1);
            end
        end
    end

endmodule

// File: rtl/out_fm_st_ctrl.sv
// Streams one output tile from the on-chip buffer to memory through a
// 2-entry skid FIFO on a valid/ready write channel.
module out_fm_st_ctrl #(
    parameter int unsigned CW = 16,
    parameter int unsigned AW = 32,
    parameter int unsigned BW = 12,
    parameter int unsigned DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [AW-1:0] row_stride,
    input  logic [CW-1:0] n0,
    input  logic [CW-1:0] n1,
    output logic          buf_rd_en,
    output logic [BW-1:0] buf_rd_addr,
    input  logic [DW-1:0] buf_rd_data,
    output logic          wr_valid,
    input  logic          wr_ready,
    output logic [AW-1:0] wr_addr,
    output logic [DW-1:0] wr_data,
    output logic          busy,
    output logic          done
);

    import out_fm_pkg::*;

    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;

    logic [AW-1:0] r_row_base;
    logic [AW-1:0] r_stride;
    logic          r_zero;
    logic [BW-1:0] r_lin;
    logic          r_inflight;
    logic [AW-1:0] r_inf_addr;

    logic [AW-1:0] r_fifo_addr [2];
    logic [DW-1:0] r_fifo_data [2];
    logic          r_wptr;
    logic          r_rptr;
    logic [1:0]    r_occ;

    logic          w_accept;
    logic          w_pop;
    logic          w_push;
    logic          w_issue;
    logic [AW-1:0] w_issue_addr;
    logic [CW-1:0] w_cnt0;
    logic          w_wrap;
    logic          w_last;

    assign w_accept     = (r_state == ST_IDLE) && start;
    assign w_pop        = (r_occ != 2'd0) && wr_ready;
    assign w_push       = r_inflight;
    assign w_issue      = (r_state == ST_STREAM) && !r_zero && issue_ok(r_occ, r_inflight, w_pop);
    assign w_issue_addr = r_row_base + AW'(w_cnt0);

    assign buf_rd_en   = w_issue;
    assign buf_rd_addr = r_lin;
    assign wr_valid    = (r_occ != 2'd0);
    assign wr_addr     = wr_valid ? r_fifo_addr[r_rptr] : '0;
    assign wr_data     = wr_valid ? r_fifo_data[r_rptr] : '0;
    assign busy        = (r_state != ST_IDLE);
    assign done        = (r_state == ST_DONE);

    st_tile_idx_counter #(
        .CW (CW)
    ) u_idx (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_accept),
        .i_n0   (n0),
        .i_n1   (n1),
        .i_en   (w_issue),
        .o_cnt0 (w_cnt0),
        .o_wrap (w_wrap),
        .o_last (w_last)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state; drain ends once the final pop empties the pipeline.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (r_zero) begin
                    w_state_nxt = ST_DONE;
                end else if (w_issue && w_last) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!r_inflight && ((r_occ == 2'd0) || ((r_occ == 2'd1) && w_pop))) begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Tile config, linear buffer address, row-base accumulator, in-flight tag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_row_base <= '0;
            r_stride   <= '0;
            r_zero     <= 1'b0;
            r_lin      <= '0;
            r_inflight <= 1'b0;
            r_inf_addr <= '0;
        end else begin
            if (w_accept) begin
                r_row_base <= base_addr;
                r_stride   <= row_stride;
                r_zero     <= (n0 == '0) || (n1 == '0);
                r_lin      <= '0;
            end else if (w_issue) begin
                r_lin <= r_lin + BW'(1);
                if (w_wrap) begin
                    r_row_base <= r_row_base + r_stride;
                end
            end
            r_inflight <= w_issue;
            if (w_issue) begin
                r_inf_addr <= w_issue_addr;
            end
        end
    end

    // Skid FIFO: returned word plus its tagged address, popped by the write channel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fifo_addr[0] <= '0;
            r_fifo_addr[1] <= '0;
            r_fifo_data[0] <= '0;
            r_fifo_data[1] <= '0;
            r_wptr         <= 1'b0;
            r_rptr         <= 1'b0;
            r_occ          <= 2'd0;
        end else begin
            if (w_push) begin
                r_fifo_addr[r_wptr] <= r_inf_addr;
                r_fifo_data[r_wptr] <= buf_rd_data;
                r_wptr              <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            r_occ <= r_occ + 2'(w_push) - 2'(w_pop);
        end
    end

endmodule

// File: tb/tb_out_fm_st_ctrl.sv
// Directed bench for the output-tile store controller.
module tb_out_fm_st_ctrl;

    localparam int unsigned CW = 16;
    localparam int unsigned AW = 32;
    localparam int unsigned BW = 12;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW-1:0] row_stride;
    logic [CW-1:0] n0;
    logic [CW-1:0] n1;
    logic          buf_rd_en;
    logic [BW-1:0] buf_rd_addr;
    logic [DW-1:0] buf_rd_data;
    logic          wr_valid;
    logic          wr_ready;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          busy;
    logic          done;

    int n_chk  = 0;
    int n_pass = 0;

    int edge_cnt = 0;
    int clr_gen  = 0;
    int seen_gen = 0;
    int rdy_mode = 0;
    int rdy_stop = 0;

    logic [BW-1:0] rd_q [$];
    logic [AW-1:0] wa_q [$];
    logic [DW-1:0] wd_q [$];
    int            done_q [$];
    int            first_wv = -1;
    int            stab_err = 0;
    int            max_out  = 0;
    logic          pv = 1'b0;
    logic          pr = 1'b0;
    logic [AW-1:0] pa = '0;
    logic [DW-1:0] pd = '0;

    out_fm_st_ctrl #(.CW(CW), .AW(AW), .BW(BW), .DW(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .base_addr   (base_addr),
        .row_stride  (row_stride),
        .n0          (n0),
        .n1          (n1),
        .buf_rd_en   (buf_rd_en),
        .buf_rd_addr (buf_rd_addr),
        .buf_rd_data (buf_rd_data),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    // Buffer contents as a function of address.
    function automatic logic [DW-1:0] bm(input logic [BW-1:0] a);
        return {a[7:0], 4'hA, a, 8'h5C};
    endfunction

    // Buffer model: one-cycle read latency, garbage when not read.
    always @(posedge clk) begin
        buf_rd_data <= buf_rd_en ? bm(buf_rd_addr) : 32'hDEAD_BEEF;
        edge_cnt    <= edge_cnt + 1;
    end

    // Monitor: log reads, accepted writes, done pulses, stability and outstanding depth.
    always @(negedge clk) begin
        if (seen_gen != clr_gen) begin
            seen_gen = clr_gen;
            rd_q.delete();
            wa_q.delete();
            wd_q.delete();
            done_q.delete();
            first_wv = -1;
            stab_err = 0;
            max_out  = 0;
            pv       = 1'b0;
        end
        if (buf_rd_en) rd_q.push_back(buf_rd_addr);
        if (wr_valid && wr_ready) begin
            wa_q.push_back(wr_addr);
            wd_q.push_back(wr_data);
        end
        if (done) done_q.push_back(edge_cnt);
        if (wr_valid && first_wv < 0) first_wv = edge_cnt;
        if (!rst && pv && !pr && (!wr_valid || wr_addr !== pa || wr_data !== pd)) stab_err++;
        pv = wr_valid && !rst;
        pr = wr_ready;
        pa = wr_addr;
        pd = wr_data;
        if (int'(rd_q.size()) - int'(wa_q.size()) > max_out)
            max_out = int'(rd_q.size()) - int'(wa_q.size());
    end

    // Write-channel ready driver.
    initial begin
        wr_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       wr_ready = 1'b1;
                1:       wr_ready = ($urandom_range(0, 9) < 3);
                default: wr_ready = (int'(wa_q.size()) < rdy_stop);
            endcase
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Run one tile from start to done and compare everything it produced.
    task automatic run_tile(input string nm, input logic [AW-1:0] b, input logic [AW-1:0] s,
                            input logic [CW-1:0] c0, input logic [CW-1:0] c1,
                            input bit timed, input bit poke);
        int n;
        int e0;
        int k;
        int idx;
        logic [AW-1:0] ea;
        logic [BW-1:0] el;
        n = int'(c0) * int'(c1);
        clr_gen++;
        base_addr  = b;
        row_stride = s;
        n0         = c0;
        n1         = c1;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start      = 1'b0;
        e0         = edge_cnt;
        base_addr  = 32'h0BAD_0000;
        row_stride = 32'h3;
        n0         = 16'd7;
        n1         = 16'd7;
        @(negedge clk);
        chk({nm, ".busy_c1"}, 64'(busy), 64'(1));
        chk({nm, ".rd_en_c1"}, 64'(buf_rd_en), 64'(n > 0));
        k = 0;
        while (done_q.size() == 0 && k < 400) begin
            @(posedge clk);
            #1;
            start = poke && (k == 3);
            k++;
        end
        start = 1'b0;
        chk({nm, ".done_cnt"}, 64'(done_q.size()), 64'(1));
        if (timed && done_q.size() > 0)
            chk({nm, ".done_cyc"}, 64'(done_q[0] - e0 + 1), 64'((n == 0) ? 2 : n + 3));
        if (timed && n > 0)
            chk({nm, ".first_wv_cyc"}, 64'(first_wv - e0 + 1), 64'(3));
        chk({nm, ".n_wr"}, 64'(wa_q.size()), 64'(n));
        chk({nm, ".n_rd"}, 64'(rd_q.size()), 64'(n));
        for (int r = 0; r < int'(c1); r++) begin
            for (int c = 0; c < int'(c0); c++) begin
                idx = r * int'(c0) + c;
                ea  = b + AW'(r) * s + AW'(c);
                el  = BW'(idx);
                if (idx < int'(wa_q.size())) begin
                    chk({nm, ".wr_addr"}, 64'(wa_q[idx]), 64'(ea));
                    chk({nm, ".wr_data"}, 64'(wd_q[idx]), 64'(bm(el)));
                end
                if (idx < int'(rd_q.size()))
                    chk({nm, ".rd_addr"}, 64'(rd_q[idx]), 64'(el));
            end
        end
        chk({nm, ".wr_stable"}, 64'(stab_err), 64'(0));
        chk({nm, ".max_outstanding_le2"}, 64'(max_out <= 2), 64'(1));
    endtask

    initial begin
        int k;
        rst        = 1'b1;
        start      = 1'b0;
        base_addr  = '0;
        row_stride = '0;
        n0         = '0;
        n1         = '0;
        repeat (2) @(negedge clk);
        chk("reset.ctrl", 64'({busy, done, buf_rd_en, wr_valid, buf_rd_addr}), 64'(0));
        chk("reset.wr_addr", 64'(wr_addr), 64'(0));
        chk("reset.wr_data", 64'(wr_data), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        rdy_mode = 0;
        run_tile("ready1", 32'h100, 32'd16, 16'd4, 16'd3, 1'b1, 1'b0);
        rdy_mode = 1;
        run_tile("bp", 32'h100, 32'd16, 16'd4, 16'd3, 1'b0, 1'b1);
        rdy_mode = 0;
        run_tile("zero", 32'h200, 32'd8, 16'd0, 16'd5, 1'b1, 1'b0);
        run_tile("b2b_a", 32'h300, 32'd4, 16'd2, 16'd2, 1'b1, 1'b0);
        run_tile("b2b_b", 32'h400, 32'd100, 16'd3, 16'd1, 1'b1, 1'b0);
        run_tile("wrap", 32'hFFFF_FFFE, 32'd0, 16'd4, 16'd1, 1'b1, 1'b0);

        // Abort mid-tile while the fifth write is stalled.
        rdy_mode   = 2;
        rdy_stop   = 4;
        clr_gen++;
        base_addr  = 32'h100;
        row_stride = 32'd16;
        n0         = 16'd4;
        n1         = 16'd3;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        k = 0;
        while (!(wa_q.size() == 4 && wr_valid && !wr_ready) && k < 100) begin
            @(posedge clk);
            #2;
            k++;
        end
        chk("rst.stall_reached", 64'(k < 100), 64'(1));
        rst = 1'b1;
        #1;
        chk("rst.ctrl", 64'({busy, done, buf_rd_en, wr_valid, buf_rd_addr}), 64'(0));
        chk("rst.wr_addr", 64'(wr_addr), 64'(0));
        chk("rst.wr_data", 64'(wr_data), 64'(0));
        repeat (3) @(negedge clk);
        chk("rst.no_done", 64'(done_q.size()), 64'(0));
        @(posedge clk);
        #1;
        rst      = 1'b0;
        rdy_mode = 0;
        @(posedge clk);
        #1;
        run_tile("post_rst", 32'h100, 32'd16, 16'd4, 16'd3, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
